// File: rtl/periph_interco_pkg.sv
// Shared definitions for the peripheral interconnect arbiters.
// Holds the arbiter FSM state type and the round-robin wrap helper.
package periph_interco_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StLocked
   } arb_state_e;

   localparam int unsigned N_MASTER_DEFAULT = 16;
   localparam int unsigned LOG_MASTER       = $clog2(N_MASTER_DEFAULT);

   // Increment modulo n; keeps the pointer valid for non-power-of-2 master counts.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      if (idx + 1 >= n) begin
         return 32'd0;
      end
      return idx + 1;
   endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Rotating-priority selector: finds the first asserted request at or after ptr,
// wrapping around, and returns it one-hot and as an index.
module rr_prio_select #(
   parameter int unsigned N_REQ     = 16,
   parameter int unsigned IDX_WIDTH = 4
) (
   input  logic [N_REQ-1:0]     req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic [N_REQ-1:0]     onehot,
   output logic [IDX_WIDTH-1:0] idx,
   output logic                 found
);

   int unsigned          pos;
   logic [IDX_WIDTH-1:0] pos_idx;

   always_comb begin
      onehot  = '0;
      idx     = '0;
      found   = 1'b0;
      pos     = 32'd0;
      pos_idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         // ptr is always < N_REQ, so a single subtraction is enough to wrap
         pos = 32'(ptr) + i;
         if (pos >= N_REQ) begin
            pos = pos - N_REQ;
         end
         pos_idx = IDX_WIDTH'(pos);
         if (!found && req[pos_idx]) begin
            found           = 1'b1;
            idx             = pos_idx;
            onehot[pos_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/per_slave_rr_arbiter.sv
// Per-slave round-robin arbiter: shares one peripheral slave port between N_MASTER
// requesters, locks the selection until granted, and back-routes registered responses.
module per_slave_rr_arbiter
   import periph_interco_pkg::*;
#(
   parameter int unsigned N_MASTER   = 16,
   parameter int unsigned ID_WIDTH   = 16,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_MASTER-1:0]            data_req_i,
   input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
   input  logic [N_MASTER-1:0]            data_wen_i,
   input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
   input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
   input  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i,
   output logic [N_MASTER-1:0]            data_gnt_o,
   output logic                           data_req_o,
   output logic [ADDR_WIDTH-1:0]          data_add_o,
   output logic                           data_wen_o,
   output logic [DATA_WIDTH-1:0]          data_wdata_o,
   output logic [BE_WIDTH-1:0]            data_be_o,
   output logic [ID_WIDTH-1:0]            data_ID_o,
   input  logic                           data_gnt_i,
   input  logic                           data_r_valid_i,
   input  logic [ID_WIDTH-1:0]            data_r_ID_i,
   output logic [N_MASTER-1:0]            data_r_valid_o
);

   localparam int unsigned LOG_M = $clog2(N_MASTER);

   arb_state_e          state_q, state_d;
   logic [LOG_M-1:0]    rr_ptr_q, rr_ptr_d;
   logic [LOG_M-1:0]    lock_idx_q, lock_idx_d;
   logic [N_MASTER-1:0] r_valid_q;

   logic [N_MASTER-1:0] win_onehot;
   logic [LOG_M-1:0]    win_idx;
   logic                win_found;

   logic [LOG_M-1:0]    sel_idx;
   logic                req_sel;
   logic [N_MASTER-1:0] gnt_vec;

   rr_prio_select #(
      .N_REQ    (N_MASTER),
      .IDX_WIDTH(LOG_M)
   ) u_prio_select (
      .req   (data_req_i),
      .ptr   (rr_ptr_q),
      .onehot(win_onehot),
      .idx   (win_idx),
      .found (win_found)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_idx_d = lock_idx_q;
      sel_idx    = win_found ? win_idx : rr_ptr_q;
      req_sel    = 1'b0;
      gnt_vec    = '0;
      unique case (state_q)
         StIdle: begin
            req_sel = win_found;
            if (win_found) begin
               gnt_vec = win_onehot & {N_MASTER{data_gnt_i}};
               if (data_gnt_i) begin
                  rr_ptr_d = LOG_M'(rr_next(32'(win_idx), N_MASTER));
               end else begin
                  lock_idx_d = win_idx;
                  state_d    = StLocked;
               end
            end
         end
         StLocked: begin
            // Hold the selection until the slave accepts, ignoring other requesters
            sel_idx = lock_idx_q;
            req_sel = data_req_i[lock_idx_q];
            if (!req_sel) begin
               state_d = StIdle;
            end else if (data_gnt_i) begin
               gnt_vec[lock_idx_q] = 1'b1;
               rr_ptr_d            = LOG_M'(rr_next(32'(lock_idx_q), N_MASTER));
               state_d             = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
         r_valid_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         r_valid_q  <= {N_MASTER{data_r_valid_i}} & data_r_ID_i[N_MASTER-1:0];
      end
   end

   // Requests are combinational, so silence them while reset is held
   assign data_req_o = req_sel & rst_n;
   assign data_gnt_o = gnt_vec & {N_MASTER{rst_n}};

   assign data_add_o   = data_add_i[32'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign data_wen_o   = data_wen_i[sel_idx];
   assign data_wdata_o = data_wdata_i[32'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign data_be_o    = data_be_i[32'(sel_idx)*BE_WIDTH +: BE_WIDTH];
   assign data_ID_o    = data_ID_i[32'(sel_idx)*ID_WIDTH +: ID_WIDTH];

   assign data_r_valid_o = r_valid_q;

endmodule

// File: tb/tb_per_slave_rr_arbiter.sv
// Directed bench for per_slave_rr_arbiter with four masters.
module tb_per_slave_rr_arbiter;
   import periph_interco_pkg::*;

   localparam int unsigned NM = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;
   localparam int unsigned IW = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NM-1:0]     data_req_i;
   logic [NM*AW-1:0]  data_add_i;
   logic [NM-1:0]     data_wen_i;
   logic [NM*DW-1:0]  data_wdata_i;
   logic [NM*BW-1:0]  data_be_i;
   logic [NM*IW-1:0]  data_ID_i;
   logic [NM-1:0]     data_gnt_o;
   logic              data_req_o;
   logic [AW-1:0]     data_add_o;
   logic              data_wen_o;
   logic [DW-1:0]     data_wdata_o;
   logic [BW-1:0]     data_be_o;
   logic [IW-1:0]     data_ID_o;
   logic              data_gnt_i;
   logic              data_r_valid_i;
   logic [IW-1:0]     data_r_ID_i;
   logic [NM-1:0]     data_r_valid_o;

   int n_cmp = 0;
   int n_mis = 0;

   per_slave_rr_arbiter #(
      .N_MASTER  (NM),
      .ID_WIDTH  (IW),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .BE_WIDTH  (BW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_req_i    (data_req_i),
      .data_add_i    (data_add_i),
      .data_wen_i    (data_wen_i),
      .data_wdata_i  (data_wdata_i),
      .data_be_i     (data_be_i),
      .data_ID_i     (data_ID_i),
      .data_gnt_o    (data_gnt_o),
      .data_req_o    (data_req_o),
      .data_add_o    (data_add_o),
      .data_wen_o    (data_wen_o),
      .data_wdata_o  (data_wdata_o),
      .data_be_o     (data_be_o),
      .data_ID_o     (data_ID_o),
      .data_gnt_i    (data_gnt_i),
      .data_r_valid_i(data_r_valid_i),
      .data_r_ID_i   (data_r_ID_i),
      .data_r_valid_o(data_r_valid_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      data_req_i     = '0;
      data_gnt_i     = 1'b0;
      data_r_valid_i = 1'b0;
      data_r_ID_i    = '0;
      for (int i = 0; i < NM; i++) begin
         data_add_i[i*AW +: AW]   = 32'h1000_0000 + 32'(i) * 32'h10;
         data_wdata_i[i*DW +: DW] = 32'hA500_0000 + 32'(i);
         data_be_i[i*BW +: BW]    = 4'hF - 4'(i);
         data_wen_i[i]            = i[0];
         data_ID_i[i*IW +: IW]    = 4'b0001 << i;
      end

      // Reset
      #1;
      check("rst_req_o", 32'(data_req_o), 32'h0);
      check("rst_gnt_o", 32'(data_gnt_o), 32'h0);
      check("rst_rvalid", 32'(data_r_valid_o), 32'h0);
      check("rst_state", 32'(dut.state_q), 32'(StIdle));
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_rvalid", 32'(data_r_valid_o), 32'h0);
      check("post_rst_ptr", 32'(dut.rr_ptr_q), 32'h0);

      // All request, slave always grants: 0,1,2,3 in turn
      data_req_i = 4'b1111;
      data_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #2;
         check("rr_gnt", 32'(data_gnt_o), 32'(4'b0001 << k));
         check("rr_add", data_add_o, 32'h1000_0000 + 32'(k) * 32'h10);
         check("rr_id", 32'(data_ID_o), 32'(4'b0001 << k));
         tick();
      end
      check("rr_ptr_wrap", 32'(dut.rr_ptr_q), 32'h0);

      // Master 2 locks while master 0 joins
      data_req_i = 4'b0100;
      data_gnt_i = 1'b0;
      #2;
      check("lk_req_o", 32'(data_req_o), 32'h1);
      check("lk_gnt0", 32'(data_gnt_o), 32'h0);
      check("lk_add0", data_add_o, 32'h1000_0020);
      tick();
      check("lk_state", 32'(dut.state_q), 32'(StLocked));
      data_req_i = 4'b0101;
      #2;
      check("lk_add1", data_add_o, 32'h1000_0020);
      check("lk_gnt1", 32'(data_gnt_o), 32'h0);
      tick();
      #2;
      check("lk_add2", data_add_o, 32'h1000_0020);
      check("lk_wdata2", data_wdata_o, 32'hA500_0002);
      check("lk_be2", 32'(data_be_o), 32'hD);
      tick();
      data_gnt_i = 1'b1;
      #2;
      check("lk_gnt3", 32'(data_gnt_o), 32'b0100);
      tick();
      check("lk_ptr", 32'(dut.rr_ptr_q), 32'h3);
      check("lk_idle", 32'(dut.state_q), 32'(StIdle));

      // rr_ptr = 3, only master 0: wraps to 0
      data_req_i = 4'b0001;
      #2;
      check("wrap_gnt", 32'(data_gnt_o), 32'b0001);
      check("wrap_wen", 32'(data_wen_o), 32'h0);
      tick();
      check("wrap_ptr", 32'(dut.rr_ptr_q), 32'h1);

      // No request: no grant even with slave grant high; payload from rr_ptr
      data_req_i = 4'b0000;
      #2;
      check("noreq_req", 32'(data_req_o), 32'h0);
      check("noreq_gnt", 32'(data_gnt_o), 32'h0);
      check("noreq_add", data_add_o, 32'h1000_0010);
      tick();
      check("noreq_ptr", 32'(dut.rr_ptr_q), 32'h1);

      // Response routing
      data_gnt_i     = 1'b0;
      data_r_valid_i = 1'b1;
      data_r_ID_i    = 4'b0100;
      #2;
      check("resp_not_early", 32'(data_r_valid_o), 32'h0);
      tick();
      check("resp_t1", 32'(data_r_valid_o), 32'b0100);
      data_r_valid_i = 1'b0;
      tick();
      check("resp_t2", 32'(data_r_valid_o), 32'h0);
      data_r_valid_i = 1'b1;
      data_r_ID_i    = 4'b0000;
      tick();
      check("resp_id0", 32'(data_r_valid_o), 32'h0);

      // Response and grant in the same cycle
      data_req_i  = 4'b0010;
      data_gnt_i  = 1'b1;
      data_r_ID_i = 4'b1000;
      #2;
      check("sim_gnt", 32'(data_gnt_o), 32'b0010);
      tick();
      check("sim_resp", 32'(data_r_valid_o), 32'b1000);
      check("sim_ptr", 32'(dut.rr_ptr_q), 32'h2);
      data_r_valid_i = 1'b0;

      // Locked requester drops its request: back to idle, pointer kept
      data_gnt_i = 1'b0;
      tick();
      check("drop_lock", 32'(dut.state_q), 32'(StLocked));
      data_req_i = 4'b0000;
      #2;
      check("drop_req_o", 32'(data_req_o), 32'h0);
      tick();
      check("drop_idle", 32'(dut.state_q), 32'(StIdle));
      check("drop_ptr", 32'(dut.rr_ptr_q), 32'h2);

      // Reset while locked with a pending response
      data_req_i = 4'b1000;
      tick();
      check("rl_lock", 32'(dut.state_q), 32'(StLocked));
      data_r_valid_i = 1'b1;
      data_r_ID_i    = 4'b0001;
      tick();
      check("rl_resp", 32'(data_r_valid_o), 32'b0001);
      #1;
      rst_n = 1'b0;
      #1;
      check("rl_state", 32'(dut.state_q), 32'(StIdle));
      check("rl_req_o", 32'(data_req_o), 32'h0);
      check("rl_gnt_o", 32'(data_gnt_o), 32'h0);
      check("rl_rvalid", 32'(data_r_valid_o), 32'h0);
      data_r_valid_i = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rl_ptr", 32'(dut.rr_ptr_q), 32'h0);
      data_req_i = 4'b1010;
      data_gnt_i = 1'b1;
      #2;
      check("rl_after_gnt", 32'(data_gnt_o), 32'b0010);
      tick();
      check("rl_after_ptr", 32'(dut.rr_ptr_q), 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
